// File: rtl/syscall_console.sv
// syscall_console: syscall responder for the single-cycle MIPS core.
// Handles print_int (code 1), print_char (code 11) and exit (code 10).
// Characters leave on a valid/ready byte port. Every output is registered.
// Optional feature macro SYSCALL_NEWLINE_EN: when defined, each print request
// is followed by a newline byte (0x0A).
module syscall_console (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        ack,
    output logic        busy,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SIGN = 3'd1,
        ST_CONV = 3'd2,
        ST_EMIT = 3'd3,
        ST_CHAR = 3'd4,
        ST_NL   = 3'd5,
        ST_DONE = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    // Powers of ten used by the repeated-subtraction decimal converter.
    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            4'd9:    pow10 = 32'd1000000000;
            default: pow10 = 32'd1;
        endcase
    endfunction

    state_t      state_r, state_next_s;
    logic [31:0] mag_r, mag_next_s;
    logic [3:0]  pidx_r, pidx_next_s;
    logic [3:0]  digit_r, digit_next_s;
    logic        started_r, started_next_s;
    logic [7:0]  char_r, char_next_s;
    logic        halted_r, halted_next_s;
    logic        err_r, err_next_s;
    logic [7:0]  byte_next_s;
    logic        valid_next_s;
    logic [31:0] pow_s;

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_next_s   = state_r;
        mag_next_s     = mag_r;
        pidx_next_s    = pidx_r;
        digit_next_s   = digit_r;
        started_next_s = started_r;
        char_next_s    = char_r;
        halted_next_s  = halted_r;
        err_next_s     = err_r;
        byte_next_s    = char_data;
        pow_s          = pow10(pidx_r);
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    err_next_s  = 1'b0;
                    char_next_s = a0[7:0];
                    if (v0 == 32'd1) begin
                        pidx_next_s    = 4'd9;
                        digit_next_s   = 4'd0;
                        started_next_s = 1'b0;
                        if (a0[31]) begin
                            // Two's complement magnitude; 0x80000000 stays 2^31 unsigned.
                            mag_next_s   = ~a0 + 32'd1;
                            state_next_s = ST_SIGN;
                            byte_next_s  = 8'h2D;
                        end else begin
                            mag_next_s   = a0;
                            state_next_s = ST_CONV;
                        end
                    end else if (v0 == 32'd11) begin
                        state_next_s = ST_CHAR;
                        byte_next_s  = a0[7:0];
                    end else if (v0 == 32'd10) begin
                        halted_next_s = 1'b1;
                        state_next_s  = ST_DONE;
                    end else begin
                        err_next_s   = 1'b1;
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SIGN: begin
                if (char_ready) begin
                    state_next_s = ST_CONV;
                end else begin
                    state_next_s = ST_SIGN;
                end
            end
            ST_CONV: begin
                if (mag_r >= pow_s) begin
                    mag_next_s   = mag_r - pow_s;
                    digit_next_s = digit_r + 4'd1;
                end else if ((digit_r != 4'd0) || started_r || (pidx_r == 4'd0)) begin
                    state_next_s = ST_EMIT;
                    byte_next_s  = 8'h30 + {4'h0, digit_r};
                end else begin
                    // Leading zero: skip this position silently.
                    pidx_next_s = pidx_r - 4'd1;
                end
            end
            ST_EMIT: begin
                if (char_ready) begin
                    started_next_s = 1'b1;
                    digit_next_s   = 4'd0;
                    if (pidx_r == 4'd0) begin
                        state_next_s = ST_NL;
                        byte_next_s  = 8'h0A;
                    end else begin
                        pidx_next_s  = pidx_r - 4'd1;
                        state_next_s = ST_CONV;
                    end
                end else begin
                    state_next_s = ST_EMIT;
                end
            end
            ST_CHAR: begin
                if (char_ready) begin
                    state_next_s = ST_NL;
                    byte_next_s  = 8'h0A;
                end else begin
                    state_next_s = ST_CHAR;
                end
            end
            ST_NL: begin
`ifdef SYSCALL_NEWLINE_EN
                if (char_ready) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_NL;
                end
`else
                state_next_s = ST_DONE;
`endif
            end
            ST_DONE: begin
                if (halted_r) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Which next states present a byte on the character port.
    always_comb begin
        case (state_next_s)
            ST_SIGN: valid_next_s = 1'b1;
            ST_EMIT: valid_next_s = 1'b1;
            ST_CHAR: valid_next_s = 1'b1;
`ifdef SYSCALL_NEWLINE_EN
            ST_NL:   valid_next_s = 1'b1;
`endif
            default: valid_next_s = 1'b0;
        endcase
    end

    // State, datapath and registered-output update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            mag_r      <= 32'd0;
            pidx_r     <= 4'd0;
            digit_r    <= 4'd0;
            started_r  <= 1'b0;
            char_r     <= 8'd0;
            halted_r   <= 1'b0;
            err_r      <= 1'b0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            char_valid <= 1'b0;
            char_data  <= 8'd0;
        end else begin
            state_r    <= state_next_s;
            mag_r      <= mag_next_s;
            pidx_r     <= pidx_next_s;
            digit_r    <= digit_next_s;
            started_r  <= started_next_s;
            char_r     <= char_next_s;
            halted_r   <= halted_next_s;
            err_r      <= err_next_s;
            ack        <= (state_next_s == ST_DONE);
            busy       <= (state_next_s != ST_IDLE) && (state_next_s != ST_HALT);
            char_valid <= valid_next_s;
            char_data  <= byte_next_s;
        end
    end

    assign halted = halted_r;
    assign err    = err_r;

endmodule

// File: tb/tb_syscall_console.sv
// Self-checking bench for syscall_console: directed and randomized requests
// compared against a decimal-formatting reference model.
module tb_syscall_console;

    logic        clock;
    logic        reset;
    logic        req;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        ack;
    logic        busy;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        halted;
    logic        err;

    int vectors;
    int miscompares;
    int ack_cnt;
    int ready_mode;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       exp_err;
    logic       hold_pending;
    logic [7:0] hold_data;

    syscall_console dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .v0         (v0),
        .a0         (a0),
        .ack        (ack),
        .busy       (busy),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .halted     (halted),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Byte capture, ack counting and stall-stability check on each rising edge.
    always @(posedge clock) begin
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", {31'd0, char_valid}, 32'd1);
                check("hold_data", {24'd0, char_data}, {24'd0, hold_data});
            end
            if (char_valid && char_ready) got_q.push_back(char_data);
            if (ack) ack_cnt++;
            hold_pending = char_valid && !char_ready;
            hold_data    = char_data;
        end
    end

    // Sink readiness: always ready, toggling, or random.
    initial begin
        char_ready = 1'b1;
        forever begin
            @(negedge clock);
            case (ready_mode)
                0:       char_ready = 1'b1;
                1:       char_ready = ~char_ready;
                default: char_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model: expected byte stream from the syscall rules.
    task automatic model(input logic [31:0] code, input logic [31:0] arg);
        longint val;
        logic [7:0] digs[$];
        int r;
        exp_q = {};
        exp_err = 1'b0;
        if (code == 32'd1) begin
            val = longint'($signed(arg));
            if (val < 0) begin
                exp_q.push_back(8'h2D);
                val = -val;
            end
            do begin
                r = int'(val % 10);
                digs.push_front(8'h30 + 8'(r));
                val = val / 10;
            end while (val != 0);
            foreach (digs[i]) exp_q.push_back(digs[i]);
`ifdef SYSCALL_NEWLINE_EN
            exp_q.push_back(8'h0A);
`endif
        end else if (code == 32'd11) begin
            exp_q.push_back(arg[7:0]);
`ifdef SYSCALL_NEWLINE_EN
            exp_q.push_back(8'h0A);
`endif
        end else if (code != 32'd10) begin
            exp_err = 1'b1;
        end
    endtask

    task automatic run_req(input logic [31:0] code, input logic [31:0] arg,
                           input int exp_lat, input string tag);
        int cyc;
        bit seen;
        model(code, arg);
        got_q   = {};
        ack_cnt = 0;
        @(negedge clock);
        req = 1'b1;
        v0  = code;
        a0  = arg;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (ack) seen = 1'b1;
        end
        req = 1'b0;
        check({tag, "_ack_seen"}, {31'd0, seen}, 32'd1);
        if (exp_lat > 0) check({tag, "_latency"}, cyc, exp_lat);
        repeat (3) @(negedge clock);
        check({tag, "_ack_count"}, ack_cnt, 32'd1);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int bound;
        logic [31:0] rc;
        logic [31:0] ra;
        vectors      = 0;
        miscompares  = 0;
        ack_cnt      = 0;
        ready_mode   = 0;
        hold_pending = 1'b0;
        hold_data    = 8'd0;
        reset = 1'b1;
        req   = 1'b0;
        v0    = 32'd0;
        a0    = 32'd0;
        repeat (2) @(negedge clock);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, char_valid}, 32'd0);
        check("rst_data", {24'd0, char_data}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;

        run_req(32'd1, 32'd0, 0, "int_zero");
        run_req(32'd1, 32'hFFFF_FF85, 0, "int_neg123");
        run_req(32'd1, 32'h8000_0000, 0, "int_min");
        run_req(32'd1, 32'h7FFF_FFFF, 0, "int_max");
        run_req(32'd11, 32'h0000_0141, 3, "char_A");

        ready_mode = 1;
        run_req(32'd1, 32'd4096, 0, "int_4096_bp");

        ready_mode = 2;
        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: rc = 32'd1;
                3, 4:    rc = 32'd11;
                default: rc = 32'($urandom_range(12, 40));
            endcase
            case ($urandom_range(0, 2))
                0:       ra = 32'($urandom_range(0, 1000));
                1:       ra = -32'($urandom_range(0, 1000));
                default: ra = $urandom;
            endcase
            run_req(rc, ra, 0, "rand");
        end

        ready_mode = 0;
        run_req(32'd5, 32'd77, 1, "unsupported");
        check("unsupported_halted", {31'd0, halted}, 32'd0);
        run_req(32'd11, 32'h0000_0030, 3, "err_clear");

        // Reset in the middle of printing 99999.
        got_q   = {};
        ack_cnt = 0;
        @(negedge clock);
        req = 1'b1;
        v0  = 32'd1;
        a0  = 32'd99999;
        bound = 0;
        while (got_q.size() == 0 && bound < 200) begin
            @(negedge clock);
            bound++;
        end
        check("midrst_first_seen", {31'd0, got_q.size() != 0}, 32'd1);
        if (got_q.size() != 0) check("midrst_first_byte", {24'd0, got_q[0]}, 32'h39);
        reset = 1'b1;
        #1;
        check("midrst_valid", {31'd0, char_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("midrst_no_ack", ack_cnt, 32'd0);
        check("midrst_nbytes", got_q.size(), 32'd1);
        run_req(32'd11, 32'h0000_005A, 3, "after_rst");

        // Exit, then a request that must be ignored.
        run_req(32'd10, 32'd0, 1, "exit");
        check("exit_halted", {31'd0, halted}, 32'd1);
        got_q   = {};
        ack_cnt = 0;
        @(negedge clock);
        req = 1'b1;
        v0  = 32'd1;
        a0  = 32'd42;
        repeat (50) @(negedge clock);
        check("halt_no_ack", ack_cnt, 32'd0);
        check("halt_no_bytes", got_q.size(), 32'd0);
        check("halt_busy", {31'd0, busy}, 32'd0);
        check("halt_sticky", {31'd0, halted}, 32'd1);
        req = 1'b0;
        reset = 1'b1;
        #1;
        check("halt_reset_clear", {31'd0, halted}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_req(32'd1, 32'd7, 0, "post_halt");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/syscall_console.md
# syscall_console

Syscall responder for the single-cycle MIPS core. It accepts a request (`$v0` code, `$a0` argument) from the core's syscall decode and services it. Print requests are streamed out as ASCII bytes on a valid/ready character port; exit requests raise a sticky halt flag. The core stalls while the request is outstanding and completes it on the one-cycle `ack`.

## Interface
- No parameters.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in 1: syscall request. Held by the requester until `ack`.
- `v0` in 32: syscall code. Sampled on the accept cycle.
- `a0` in 32: syscall argument. Sampled on the accept cycle.
- `ack` out 1: one-cycle completion pulse.
- `busy` out 1: high in any state other than IDLE and HALT.
- `char_valid` out 1: a character byte is presented.
- `char_data` out 8: ASCII byte.
- `char_ready` in 1: the sink accepts the byte this cycle.
- `halted` out 1: sticky exit flag.
- `err` out 1: the last accepted code was unsupported.

## Operation
- **Supported codes:** 1 = print_int (signed decimal of `a0`); 11 = print_char (`a0[7:0]`); 10 = exit. Any other code is unsupported.
- **States:** IDLE, SIGN, CONV, EMIT, CHAR, NL, DONE, HALT.
- **IDLE, on `req`:** capture `v0` and `a0`, clear `err`, then branch on the code:
  - Code 1 with `a0[31]=1`: mag=~a0+1 (32-bit unsigned, so 0x80000000 gives 2147483648); go to SIGN.
  - Code 1 with `a0[31]=0`: mag=a0; go to CONV.
  - Code 1, both cases: pidx=9, digit=0, started=0.
  - Code 11: go to CHAR.
  - Code 10: set `halted`; go to DONE.
  - Other: set `err`; go to DONE.
- **SIGN:** present 0x2D ('-'). On `char_ready`, go to CONV.
- **CONV:** uses a constant table pow[0..9] = 10^0..10^9.
  - If mag ≥ pow[pidx]: mag -= pow[pidx], digit++ (4-bit); stay in CONV.
  - Else, if digit≠0 or started or pidx==0: go to EMIT with byte 0x30+digit.
  - Else (leading zero): pidx--; stay in CONV.
- **EMIT:** present the digit byte. On `char_ready`:
  - started=1, digit=0.
  - If pidx==0, go to NL. Otherwise pidx--, go to CONV.
- **CHAR:** present `a0[7:0]` unchanged. On `char_ready`, go to NL.
- **NL:** newline stage; see Configuration.
- **DONE:** `ack`=1 for exactly one cycle. Go to HALT if `halted`, else to IDLE.
- **HALT:** absorbing state. `req` is ignored and no further `ack` is produced. Only `reset` leaves HALT.
- **Output:** a zero argument prints the single byte 0x30. Leading zeros are never emitted.

## Timing
- **Reset values:** every output is 0 and the state is IDLE, asynchronously.
  - Reset during SIGN, CONV, EMIT, CHAR or NL aborts the request and drops `char_valid` immediately; no `ack` is issued.
- **Outputs:** all registered.
- **Character handshake:** a byte transfers on a rising edge with `char_valid`=1 and `char_ready`=1.
  - Once `char_valid` is asserted, `char_data` holds stable and `char_valid` stays high until the transfer.
  - `char_ready` may be high permanently.
- **Request handshake:**
  - `req` is sampled only in IDLE.
  - Requester drops `req` in the cycle after `ack`.
  - A `req` still high in the IDLE cycle after DONE starts a new request.
- **Latency, `char_ready`=1:**
  - Exit and unsupported codes: accept → DONE, so `ack` arrives 1 cycle after the accept edge.
  - print_char: accept, CHAR, (NL), DONE.
  - print_int: at most 10 CONV cycles per digit position; bounded by 120 cycles.
- **Stalls:** a stall on `char_ready` extends latency cycle-for-cycle; no byte is lost or duplicated.

## Configuration
- **`SYSCALL_NEWLINE_EN` defined:** NL presents 0x0A under the same valid/ready rules, then goes to DONE.
- **Not defined:** NL falls through to DONE in one cycle with `char_valid`=0. Only bytes derived from the argument are emitted.
- **Codes affected:** NL is visited for codes 1 and 11 only.

## Test plan
- **print_int 0:** v0=1, a0=0, `char_ready`=1 → exactly 0x30 (+0x0A with the macro), then a single `ack`; `err`=0.
- **print_int negative:** v0=1, a0=0xFFFFFF85 (-123) → bytes 0x2D,0x31,0x32,0x33 in order.
- **print_int minimum:** v0=1, a0=0x80000000 → "-2147483648", 11 bytes.
- **Backpressure:** v0=1, a0=4096 with `char_ready` toggling 0/1 each cycle → "4096" with no drops or repeats; `char_data` stable while stalled.
- **Exit, then ignored request:** v0=10 → `halted`=1 and one `ack`. A later req with v0=1 yields no bytes and no `ack`; `reset` clears `halted`.
- **Unsupported code, then reset mid-print:** v0=5 → `err`=1, `ack` after 1 cycle, no bytes. A print_int 99999 with `reset` asserted after its first byte → `char_valid`=0 immediately, no `ack`, state IDLE.
